// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW code packer: default widths and the packer FSM state type.
package lzw_pkg;

  localparam int LZW_CODE_IN_W = 16;
  localparam int CODE_W_DEF    = 12;
  localparam int OUT_W_DEF     = 32;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/lzw_code_packer_if.sv
// Code-in / word-out handshake bundle between an LZW compressor, the packer and its sink.
interface lzw_code_packer_if
  import lzw_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
);

    logic [LZW_CODE_IN_W-1:0] in_code;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;

    // Environment side: produces codes, consumes packed words.
    modport master (
        output in_code, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Packer side.
    modport slave (
        input  in_code, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/lzw_bit_accum.sv
// Bit accumulator: ORs CODE_W-bit codes in at the current fill offset and shifts out
// OUT_W-bit words from the bottom. Bits above fill are always zero, so the low word doubles as a padded remainder.
module lzw_bit_accum
  import lzw_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              insert,
    input  logic [CODE_W-1:0] code,
    input  logic              shift_out,
    input  logic              flush,
    output logic [OUT_W-1:0]  word,
    output logic              can_accept,
    output logic              word_avail,
    output logic              has_bits
);

    localparam int ACC_W  = OUT_W + CODE_W;
    localparam int FILL_W = $clog2(ACC_W);
    localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] CODE_W_F = FILL_W'(CODE_W);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        acc_d  = acc_q;
        fill_d = fill_q;
        if (clear || flush) begin
            acc_d  = '0;
            fill_d = '0;
        end else begin
            if (shift_out) begin
                acc_d  = acc_q >> OUT_W;
                fill_d = fill_q - OUT_W_F;
            end
            // New code lands at the post-shift offset when a word leaves in the same cycle.
            if (insert) begin
                acc_d  = acc_d | (ACC_W'(code) << fill_d);
                fill_d = fill_d + CODE_W_F;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only; blocking here would race other flops.
    // NOTE: the accumulator is reset too, since stale bits would be ORed into the next stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign word       = acc_q[OUT_W-1:0];
    assign can_accept = (fill_q < OUT_W_F);
    assign word_avail = (fill_q >= OUT_W_F);
    assign has_bits   = (fill_q != '0);

endmodule

// File: rtl/lzw_code_packer.sv
// LZW code packer top: FSM, stream counters, range flag and the single output word register
// around the bit accumulator.
module lzw_code_packer
  import lzw_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    lzw_code_packer_if.slave       bus,
    output logic                   done,
    output logic [CNT_W-1:0]       word_count,
    output logic [CNT_W-1:0]       code_count,
    output logic                   err_range
);

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   word_count_q, word_count_d;
    logic [CNT_W-1:0]   code_count_q, code_count_d;
    logic               err_range_q, err_range_d;

    logic               acc_clear;
    logic               can_accept, word_avail, has_bits;
    logic [OUT_W-1:0]   acc_word;
    logic               in_ready;
    logic               accept;
    logic               out_free;
    logic               out_xfer;
    logic               load_full;
    logic               load_pad;
    logic               in_pack_or_flush;

    assign in_ready         = (state_q == PACK) && can_accept;
    assign accept           = bus.in_valid && in_ready;
    assign out_free         = !out_valid_q || bus.out_ready;
    assign out_xfer         = out_valid_q && bus.out_ready;
    assign in_pack_or_flush = (state_q == PACK) || (state_q == FLUSH);
    assign load_full        = in_pack_or_flush && word_avail && out_free;
    // Partial remainder only goes out once every full word has left the accumulator.
    assign load_pad         = (state_q == FLUSH) && has_bits && !word_avail && out_free;
    assign acc_clear        = (state_q == IDLE) && start;

    lzw_bit_accum #(
        .CODE_W (CODE_W),
        .OUT_W  (OUT_W)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .insert     (accept),
        .code       (bus.in_code[CODE_W-1:0]),
        .shift_out  (load_full),
        .flush      (load_pad),
        .word       (acc_word),
        .can_accept (can_accept),
        .word_avail (word_avail),
        .has_bits   (has_bits)
    );

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        word_count_d = word_count_q;
        code_count_d = code_count_q;
        err_range_d  = err_range_q;

        if (load_full || load_pad) begin
            out_data_d  = acc_word;
            out_valid_d = 1'b1;
        end

        if (out_xfer && (word_count_q != '1)) word_count_d = word_count_q + 1'b1;
        if (accept && (code_count_q != '1))   code_count_d = code_count_q + 1'b1;
        if (accept && (bus.in_code[LZW_CODE_IN_W-1:CODE_W] != '0)) err_range_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = PACK;
                    word_count_d = '0;
                    code_count_d = '0;
                    err_range_d  = 1'b0;
                end
            end
            PACK: begin
                if (accept && bus.in_last) state_d = FLUSH;
            end
            FLUSH: begin
                if (!has_bits && !out_valid_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
            code_count_q <= '0;
            err_range_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
            code_count_q <= code_count_d;
            err_range_q  <= err_range_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign done          = (state_q == DONE);
    assign word_count    = word_count_q;
    assign code_count    = code_count_q;
    assign err_range     = err_range_q;

endmodule

// File: tb/tb_lzw_code_packer.sv
// Scoreboard bench for lzw_code_packer (CODE_W=12, OUT_W=32): directed streams push expected
// words into a queue; a negedge monitor pops and compares on every output handshake.
module tb_lzw_code_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [15:0] word_count;
    logic [15:0] code_count;
    logic        err_range;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    lzw_code_packer_if #(.OUT_W(32)) bus ();

    lzw_code_packer #(
        .CODE_W (12),
        .OUT_W  (32),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .done       (done),
        .word_count (word_count),
        .code_count (code_count),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes at the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%08h expected none", bus.out_data);
                end else begin
                    check("word", bus.out_data, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // All driver tasks begin and end 1 time unit after a rising edge.
    task automatic send_code(input logic [15:0] c, input logic l);
        logic ok;
        int   n;
        n = 0;
        bus.in_code  = c;
        bus.in_valid = 1'b1;
        bus.in_last  = l;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("in_ready_timeout", ok, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", found, 1'b1);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // Reference packer: concatenate codes LSB-first into a wide vector, then slice words.
    task automatic push_model(input logic [11:0] codes[16], input int n);
        logic [511:0] bits;
        int           nbits;
        bits  = '0;
        nbits = 0;
        for (int i = 0; i < n; i++) begin
            bits[nbits +: 12] = codes[i];
            nbits += 12;
        end
        for (int k = 0; k < (nbits + 31) / 32; k++) exp_q.push_back(bits[32*k +: 32]);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_data"}, bus.out_data, 32'h0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_word_count"}, word_count, 16'd0);
        check({tag, "_code_count"}, code_count, 16'd0);
        check({tag, "_err_range"}, err_range, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] codes[16];

        rst           = 1'b1;
        start         = 1'b0;
        bus.in_code   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: three codes, 36 bits -> one full word plus a zero remainder word.
        exp_q.push_back(32'h03002001);
        exp_q.push_back(32'h00000000);
        do_start();
        send_code(16'h001, 1'b0);
        send_code(16'h002, 1'b0);
        send_code(16'h003, 1'b1);
        wait_done(20);
        check("t1_word_count", word_count, 16'd2);
        check("t1_code_count", code_count, 16'd3);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: single code with last.
        exp_q.push_back(32'h00000ABC);
        do_start();
        send_code(16'h0ABC, 1'b1);
        wait_done(4);
        check("t2_word_count", word_count, 16'd1);
        check("t2_code_count", code_count, 16'd1);
        check("t2_err_range", err_range, 1'b0);

        // 3: eight 0xFFF codes fill exactly three words; no padding word.
        repeat (3) exp_q.push_back(32'hFFFFFFFF);
        do_start();
        for (int i = 0; i < 8; i++) send_code(16'h0FFF, (i == 7));
        wait_done(20);
        check("t3_word_count", word_count, 16'd3);
        check("t3_code_count", code_count, 16'd8);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: sink stalls 10 cycles mid-stream; words must be held and none lost.
        codes = '{12'h101, 12'h212, 12'h323, 12'h434, 12'h545, 12'h656, 12'h767, 12'h878,
                  12'h989, 12'hA9A, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
        push_model(codes, 10);
        do_start();
        for (int i = 0; i < 4; i++) send_code({4'h0, codes[i]}, 1'b0);
        fork
            begin
                for (int i = 4; i < 10; i++) send_code({4'h0, codes[i]}, (i == 9));
            end
            begin
                bus.out_ready = 1'b0;
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("t4_stall_in_ready", bus.in_ready, 1'b0);
                check("t4_stall_out_valid", bus.out_valid, 1'b1);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_done(30);
        check("t4_word_count", word_count, 16'd4);
        check("t4_code_count", code_count, 16'd10);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: out-of-range code sets the sticky flag; low bits are still packed.
        exp_q.push_back(32'h00000ABC);
        do_start();
        send_code(16'h1ABC, 1'b1);
        wait_done(10);
        check("t5_err_range", err_range, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_err_sticky", err_range, 1'b1);
        do_start();
        @(negedge clk);
        check("t5_err_cleared", err_range, 1'b0);
        check("t5_pack_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // 6: reset after five codes discards everything; next stream packs from bit 0.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_code(16'h111 * (i + 1), 1'b0);
        check("t6_code_count_pre", code_count, 16'd5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("t6_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        codes = '{12'h00A, 12'h00B, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0,
                  12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
        push_model(codes, 2);
        do_start();
        send_code(16'h00A, 1'b0);
        send_code(16'h00B, 1'b1);
        wait_done(10);
        check("t6_word_count", word_count, 16'd1);
        check("t6_code_count", code_count, 16'd2);
        check("t6_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
